// File: rtl/xilinx_ref_clk_gen.sv
// xilinx_ref_clk_gen: per-channel integer-divider / NCO reference clocks.
// New configs wait in a shadow until the output falls or the channel is disabled.
module xilinx_ref_clk_gen #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned AccWidth    = 24,
    parameter int unsigned DefaultDiv  = 610
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumChannels-1:0]               en_i,
    input  logic [NumChannels-1:0]               cfg_load_i,
    input  logic [NumChannels-1:0]               mode_i,
    input  logic [NumChannels-1:0][CntWidth-1:0] div_i,
    input  logic [NumChannels-1:0][AccWidth-1:0] inc_i,
    output logic [NumChannels-1:0]               clk_o,
    output logic [NumChannels-1:0]               tick_o,
    output logic [NumChannels-1:0]               pending_o
);
    localparam logic [CntWidth-1:0] DefDiv = CntWidth'(DefaultDiv);
    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic                mode_q, mode_d, sh_mode_q, sh_mode_d;
        logic [CntWidth-1:0] div_q, div_d, sh_div_q, sh_div_d, cnt_q, cnt_d;
        logic [AccWidth-1:0] inc_q, inc_d, sh_inc_q, sh_inc_d, acc_q, acc_d, acc_sum;
        logic                clk_q, clk_d, tick_q, pend_q, pend_d, wrap, apply;
        always_comb begin
            acc_sum   = acc_q + inc_q;
            wrap      = cnt_q == div_q;
            clk_d     = en_i[c] & (mode_q ? acc_sum[AccWidth-1] : clk_q ^ wrap);
            sh_mode_d = cfg_load_i[c] ? mode_i[c] : sh_mode_q;
            sh_div_d  = cfg_load_i[c] ? div_i[c] : sh_div_q;
            sh_inc_d  = cfg_load_i[c] ? inc_i[c] : sh_inc_q;
            // only switch config on a falling edge (or while idle) so no high phase is truncated
            apply     = (~en_i[c] | (clk_q & ~clk_d)) & (pend_q | cfg_load_i[c]);
            pend_d    = ~apply & (pend_q | cfg_load_i[c]);
            mode_d    = apply ? sh_mode_d : mode_q;
            div_d     = apply ? sh_div_d : div_q;
            inc_d     = apply ? sh_inc_d : inc_q;
            cnt_d     = (en_i[c] & ~mode_q & ~wrap & ~apply) ? cnt_q + CntWidth'(1) : '0;
            acc_d     = (en_i[c] & mode_q & ~(apply & (sh_mode_d != mode_q))) ? acc_sum : '0;
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mode_q    <= 1'b0;
                div_q     <= DefDiv;
                inc_q     <= '0;
                sh_mode_q <= 1'b0;
                sh_div_q  <= DefDiv;
                sh_inc_q  <= '0;
                cnt_q     <= '0;
                acc_q     <= '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else begin
                mode_q    <= mode_d;
                div_q     <= div_d;
                inc_q     <= inc_d;
                sh_mode_q <= sh_mode_d;
                sh_div_q  <= sh_div_d;
                sh_inc_q  <= sh_inc_d;
                cnt_q     <= cnt_d;
                acc_q     <= acc_d;
                clk_q     <= clk_d;
                tick_q    <= ~clk_q & clk_d;
                pend_q    <= pend_d;
            end
        end
        assign clk_o[c]     = clk_q;
        assign tick_o[c]    = tick_q;
        assign pending_o[c] = pend_q;
    end
endmodule

// File: tb/tb_xilinx_ref_clk_gen.sv
// tb_xilinx_ref_clk_gen: directed stimulus with a per-cycle expected-output scoreboard
// plus hand-computed timing checks for xilinx_ref_clk_gen.
module tb_xilinx_ref_clk_gen;
    localparam int NC = 2;
    localparam int CW = 16;
    localparam int AW = 8;
    localparam int DD = 610;

    typedef struct {
        logic          mode, sm, clk, tick, pend;
        logic [CW-1:0] d, sd, cnt;
        logic [AW-1:0] inc, si, acc;
    } chan_t;

    typedef struct {
        logic [NC-1:0] clk, tick, pend;
        string         tag;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NC-1:0]          en, ld, md;
    logic [NC-1:0][CW-1:0]  dv;
    logic [NC-1:0][AW-1:0]  ic;
    logic [NC-1:0]          clk_o, tick_o, pending_o;

    chan_t m [NC];
    exp_t  sb [$];
    int    checks = 0;
    int    failures = 0;

    xilinx_ref_clk_gen #(
        .NumChannels(NC), .CntWidth(CW), .AccWidth(AW), .DefaultDiv(DD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_load_i(ld), .mode_i(md),
        .div_i(dv), .inc_i(ic), .clk_o(clk_o), .tick_o(tick_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NC; c++) begin
            m[c].mode = 1'b0; m[c].sm = 1'b0; m[c].clk = 1'b0; m[c].tick = 1'b0; m[c].pend = 1'b0;
            m[c].d = CW'(DD); m[c].sd = CW'(DD); m[c].cnt = '0;
            m[c].inc = '0; m[c].si = '0; m[c].acc = '0;
        end
    endtask

    task automatic m_step(int c);
        chan_t s, n;
        logic  bnd;
        s = m[c];
        n = s;
        if (!en[c]) begin
            n.cnt = '0; n.acc = '0; n.clk = 1'b0;
        end else if (!s.mode) begin
            if (s.cnt == s.d) begin
                n.cnt = '0; n.clk = !s.clk;
            end else n.cnt = s.cnt + 16'd1;
        end else begin
            n.acc = s.acc + s.inc;
            n.clk = n.acc[AW-1];
        end
        n.tick = !s.clk && n.clk;
        bnd = !en[c] || (s.clk && !n.clk);
        if (ld[c]) begin
            n.sm = md[c]; n.sd = dv[c]; n.si = ic[c];
        end
        if (bnd && (ld[c] || s.pend)) begin
            if (n.sm != s.mode) n.acc = '0;
            n.mode = n.sm; n.d = n.sd; n.inc = n.si; n.cnt = '0; n.pend = 1'b0;
        end else if (ld[c]) n.pend = 1'b1;
        m[c] = n;
    endtask

    // one clock: predict, push, advance, pop and compare
    task automatic step(string tag);
        exp_t e;
        for (int c = 0; c < NC; c++) m_step(c);
        for (int c = 0; c < NC; c++) begin
            e.clk[c] = m[c].clk; e.tick[c] = m[c].tick; e.pend[c] = m[c].pend;
        end
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ld = '0;
        e = sb.pop_front();
        chk({e.tag, "/clk_o"}, 32'(clk_o), 32'(e.clk));
        chk({e.tag, "/tick_o"}, 32'(tick_o), 32'(e.tick));
        chk({e.tag, "/pending_o"}, 32'(pending_o), 32'(e.pend));
    endtask

    task automatic wait_lvl(int c, logic v, int max, string tag, output int n);
        n = 0;
        while (clk_o[c] !== v && n >= 0) begin
            if (n == max) n = -1;
            else begin
                step(tag);
                n++;
            end
        end
    endtask

    initial begin
        int n, t;
        logic [7:0] pat;
        rst_n = 1'b0; en = '0; ld = '0; md = '0; dv = '0; ic = '0;
        m_reset();
        #8;
        chk("reset_clk", 32'(clk_o), 0);
        chk("reset_tick", 32'(tick_o), 0);
        chk("reset_pend", 32'(pending_o), 0);
        #15 rst_n = 1'b1;
        repeat (3) step("idle");

        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 700, "default_rise", n);
        chk("default_first_rise", n, 611);
        chk("default_tick", 32'(tick_o[0]), 1);
        wait_lvl(0, 1'b0, 700, "default_high", n);
        chk("default_high_len", n, 611);
        wait_lvl(0, 1'b1, 700, "default_low", t);
        chk("default_period", n + t, 1222);

        en[0] = 1'b0;
        step("d0_disable");
        ld[0] = 1'b1; md[0] = 1'b0; dv[0] = 16'd0;
        step("d0_load");
        en[0] = 1'b1;
        t = 0;
        for (int k = 0; k < 6; k++) begin
            step("d0_run");
            pat[k] = clk_o[0];
            t += int'(tick_o[0]);
        end
        chk("d0_pattern", 32'(pat[5:0]), 32'h15);
        chk("d0_ticks", t, 3);

        en[0] = 1'b0;
        ld[0] = 1'b1; dv[0] = 16'd3;
        step("d3_load");
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 10, "d3_rise", n);
        chk("d3_first_rise", n, 4);
        step("d3_high");
        step("d3_high");
        ld[0] = 1'b1; dv[0] = 16'd1;
        step("d1_load_mid_high");
        chk("d1_pending_set", 32'(pending_o[0]), 1);
        chk("d1_still_high", 32'(clk_o[0]), 1);
        wait_lvl(0, 1'b0, 10, "d3_fall", n);
        chk("d3_high_rest", n, 1);
        chk("d1_pending_clr", 32'(pending_o[0]), 0);
        wait_lvl(0, 1'b1, 10, "d1_low", n);
        chk("d1_low_len", n, 2);
        wait_lvl(0, 1'b0, 10, "d1_high", n);
        chk("d1_high_len", n, 2);

        ld[1] = 1'b1; md[1] = 1'b1; ic[1] = 8'd64;
        step("nco_load");
        chk("nco_direct_apply", 32'(pending_o[1]), 0);
        en[1] = 1'b1;
        t = 0;
        for (int k = 0; k < 8; k++) begin
            step("nco64_run");
            pat[k] = clk_o[1];
            t += int'(tick_o[1]);
        end
        chk("nco64_pattern", 32'(pat), 32'h66);
        chk("nco64_ticks", t, 2);
        ld[1] = 1'b1; ic[1] = 8'd3;
        step("nco3_load");
        chk("nco3_pending", 32'(pending_o[1]), 1);
        wait_lvl(1, 1'b1, 10, "nco3_wait_hi", n);
        chk("nco3_wait_hi", n, 1);
        wait_lvl(1, 1'b0, 10, "nco3_wait_fall", n);
        chk("nco3_wait_fall", n, 2);
        chk("nco3_applied", 32'(pending_o[1]), 0);
        t = 0;
        for (int k = 0; k < 256; k++) begin
            step("nco3_run");
            t += int'(tick_o[1]);
        end
        chk("nco3_ticks_256", t, 3);

        wait_lvl(0, 1'b0, 10, "drop_sync_lo", n);
        wait_lvl(0, 1'b1, 10, "drop_sync_hi", n);
        ld[0] = 1'b1; md[0] = 1'b0; dv[0] = 16'd5;
        step("drop_load");
        chk("drop_pending", 32'(pending_o[0]), 1);
        chk("drop_high", 32'(clk_o[0]), 1);
        en[0] = 1'b0;
        step("drop_en");
        chk("drop_clk_low", 32'(clk_o[0]), 0);
        chk("drop_applied", 32'(pending_o[0]), 0);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 20, "drop_reenable", n);
        chk("drop_first_phase", n, 6);

        wait_lvl(1, 1'b0, 300, "rst_sync", n);
        ld[1] = 1'b1; md[1] = 1'b1; ic[1] = 8'd5;
        step("rst_load");
        chk("rst_pending_before", 32'(pending_o[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_clk", 32'(clk_o), 0);
        chk("rst_async_tick", 32'(tick_o), 0);
        chk("rst_async_pend", 32'(pending_o), 0);
        m_reset();
        #3 rst_n = 1'b1;
        wait_lvl(1, 1'b1, 700, "rst_default", n);
        chk("rst_default_rise", n, 611);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xilinx_ref_clk_gen.md
# xilinx_ref_clk_gen

Parametrised multi-channel reference-clock generator for the Croc FPGA top level. It replaces the fixed divide-by-610 RTC divider with NumChannels independent channels. Each channel runs either as an integer divider with 50% duty cycle or as a phase-accumulator NCO. Channels reconfigure at runtime without truncated high phases, and each provides a registered clock-like output plus a single-cycle tick. It sits in the top-level wrapper in the soc_clk domain, next to rstgen, and drives ref_clk_i of croc_soc and spare timing outputs.

## Interface
- NumChannels, 2, number of independent channels (≥1)
- CntWidth, 16, integer-mode divisor/counter width
- AccWidth, 24, NCO accumulator and increment width
- DefaultDiv, 610, integer divisor for every channel after reset (must fit CntWidth)
- clk_i  in  1  single clock (soc_clk); all logic on its rising edge
- rst_ni  in  1  asynchronous, active-low reset
- en_i  in  [NumChannels-1:0]  per-channel run enable, level
- cfg_load_i  in  [NumChannels-1:0]  one-cycle pulse; latch that channel's mode_i/div_i/inc_i into shadow
- mode_i  in  [NumChannels-1:0]  0 = integer divider, 1 = NCO
- div_i  in  [NumChannels-1:0][CntWidth-1:0]  integer divisor D
- inc_i  in  [NumChannels-1:0][AccWidth-1:0]  NCO increment I
- clk_o  out  [NumChannels-1:0]  registered divided clock
- tick_o  out  [NumChannels-1:0]  one-cycle pulse, high in the cycle clk_o goes 0→1
- pending_o  out  [NumChannels-1:0]  shadow config latched, not yet applied

## Operation
- Per channel: active config (mode, D, I), shadow config, counter cnt (CntWidth), accumulator acc (AccWidth), clk_o flop, tick flop, pending flop.
- Integer mode, en=1: if cnt==D, then cnt←0 and clk_o toggles; otherwise cnt←cnt+1. f_out = f_clk/(2·(D+1)). D=0 toggles every cycle.
- NCO mode, en=1: acc←acc+I, modulo 2^AccWidth, wrap silent; clk_o←MSB of the new acc. f_out = f_clk·I/2^AccWidth. I=0 freezes clk_o.
- tick_o is registered with clk_o: tick=1 exactly when clk_o goes 0→1.
- en=0: next cycle cnt←0, acc←0, clk_o←0, tick←0, regardless of phase. A high phase may be shortened; this is intended. Re-enable starts from phase 0.
- cfg_load pulse: shadow←inputs, pending←1. A second load while pending overwrites the shadow; pending stays 1.
- Apply boundary: any cycle where clk_o goes 1→0 while en=1, or any cycle with en=0.
- At an apply boundary with pending=1: active←shadow, pending←0, cnt←0. acc←0 only if the mode changes; otherwise acc is kept (phase-continuous NCO).
- cfg_load at an apply boundary: the incoming inputs are applied directly and pending stays 0.
- Frozen NCO (I=0, clk_o=1) never reaches a boundary. Software must drop en to apply a new config.
- Channels are fully independent; no cross-channel state.

## Timing
- Reset (async assert, sync to clk_i on release): clk_o=0, tick_o=0, pending_o=0, cnt=0, acc=0, mode=integer, D=DefaultDiv, I=0, shadow=active.
- Integer: first clk_o rise D+1 enabled cycles after cnt=0. High and low phases are each D+1 cycles. tick period is 2(D+1).
- NCO: clk_o/tick reflect the accumulator one cycle after the add. Period is exact on average, with jitter ±1 cycle.
- pending_o rises the cycle after cfg_load and falls the cycle after the apply boundary.
- The new config's first edge, clk_o 0→1, comes D_new+1 cycles after the boundary.
- Reset mid-operation: outputs go to reset values immediately, and pending or shadow contents are discarded.

## Test plan
- Reset, en=1, DefaultDiv=610, integer mode → first clk_o rise 611 cycles after en; period 1222; one tick per 1222 cycles; pending_o=0 throughout.
- Load D=0 while disabled, then enable → clk_o toggles every cycle; tick every 2 cycles.
- Running D=3, cfg_load D=1 two cycles into a high phase → pending_o=1; high phase still lasts 4 cycles; after the fall, phases are 2 cycles each; pending_o clears at the fall.
- AccWidth=8, NCO I=64 → clk_o pattern 0,1,1,0 repeating after the first add; tick every 4 cycles. Then switch to I=3 at a boundary, with acc kept → average period 85.33 cycles.
- en dropped mid-high with a pending load → next cycle clk_o=0, cnt=acc=0, config applied, pending_o=0. Re-enable gives a clean first phase of D_new+1 cycles.
- Assert rst_ni mid-NCO with a pending load → clk_o/tick/pending go to 0 asynchronously; after release, the channel runs integer mode at DefaultDiv.
